// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the memory (ME) stage and its bus controller.
//   meState_t     - ME stage state encoding (IDLE / BUSY / DONE)
//   MISALIGN_MASK - low address bits that must be zero for a word access
//   isAligned()   - word-alignment test for a byte address
package mips_pkg;

    typedef enum logic [1:0] {
        ME_IDLE = 2'd0,
        ME_BUSY = 2'd1,
        ME_DONE = 2'd2
    } meState_t;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic isAligned(input logic [31:0] addr);
        return (addr[1:0] & MISALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dff.sv
// dff: W-bit D flip-flop with synchronous active-low clear.
//   clk     in  rising-edge clock
//   reset_n in  synchronous clear, active-low
//   d       in  next value
//   q       out registered value
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) q <= '0;
        else          q <= d;
    end

endmodule

// File: rtl/me_bus_ctl.sv
// me_bus_ctl: data-memory request FSM for the ME stage.
// Owns the IDLE/BUSY/DONE state, the BUSY timeout counter, the kill flag and
// the registered Dm* request outputs, and latches the writeback controls of
// the access in flight.
//   clk, reset_n                in   clock, synchronous active-low reset
//   flush                       in   pipeline kill
//   memOp, aligned              in   EX instruction is a memory op / is word aligned
//   Result_EX, WrDat_EX         in   address and store data from EX
//   WriteReg_EX, RegWrite_EX,
//   MemToReg_EX, MemWrite_EX    in   EX controls
//   DmAck                       in   memory completion pulse
//   DmReq, DmWe, DmAddr, DmWrDat out  registered memory request
//   meState                     out  current state
//   ackStrobe, timeoutStrobe    out  access completes / aborts at this edge
//   killNow                     out  result of the access must be discarded
//   memToRegLat, regWriteLat,
//   writeRegLat                 out  latched writeback controls
module me_bus_ctl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        memOp,
    input  logic        aligned,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    input  logic        DmAck,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAddr,
    output logic [31:0] DmWrDat,
    output meState_t    meState,
    output logic        ackStrobe,
    output logic        timeoutStrobe,
    output logic        killNow,
    output logic        memToRegLat,
    output logic        regWriteLat,
    output logic [4:0]  writeRegLat
);

    // Counter value seen during the last allowed BUSY cycle; TIMEOUT_CYCLES
    // must fit in CNT_W bits.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    meState_t         stateReg, stateNext;
    logic [CNT_W-1:0] cntReg;
    logic             killReg;
    logic             startReq;
    logic             inBusy;
    logic             timeoutHit;

    assign inBusy        = (stateReg == ME_BUSY);
    assign startReq      = (stateReg == ME_IDLE) & memOp & aligned & ~flush;
    assign timeoutHit    = (TIMEOUT_CYCLES != 0) && (cntReg == TO_LAST);
    assign ackStrobe     = inBusy & DmAck;
    // Ack wins when both land on the same edge.
    assign timeoutStrobe = inBusy & ~DmAck & timeoutHit;
    // A flush in the completing cycle also discards the result.
    assign killNow       = killReg | flush;
    assign meState       = stateReg;

    always_ff @(posedge clk) begin
        if (!reset_n) stateReg <= ME_IDLE;
        else          stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ME_IDLE: if (startReq) stateNext = ME_BUSY;
            ME_BUSY: if (ackStrobe || timeoutStrobe) stateNext = ME_DONE;
            ME_DONE: stateNext = ME_IDLE;
            default: stateNext = ME_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            DmReq       <= 1'b0;
            DmWe        <= 1'b0;
            DmAddr      <= '0;
            DmWrDat     <= '0;
            cntReg      <= '0;
            killReg     <= 1'b0;
            memToRegLat <= 1'b0;
            regWriteLat <= 1'b0;
            writeRegLat <= '0;
        end else if (startReq) begin
            DmReq       <= 1'b1;
            DmWe        <= MemWrite_EX;
            DmAddr      <= Result_EX;
            DmWrDat     <= WrDat_EX;
            cntReg      <= '0;
            killReg     <= 1'b0;
            memToRegLat <= MemToReg_EX;
            regWriteLat <= RegWrite_EX & ~MemWrite_EX;  // stores never write back
            writeRegLat <= WriteReg_EX;
        end else if (inBusy) begin
            if (ackStrobe || timeoutStrobe) begin
                DmReq   <= 1'b0;
                killReg <= 1'b0;
            end else begin
                cntReg  <= cntReg + CNT_W'(1);
                killReg <= killReg | flush;
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline ME stage.
// Passes ALU results straight through to the ME register, and runs loads and
// stores through a req/ack data-memory handshake while stalling the pipeline.
//   clk, reset_n, flush          in   clock, sync active-low reset, pipeline kill
//   Result_EX, WrDat_EX,
//   WriteReg_EX, RegWrite_EX,
//   MemToReg_EX, MemWrite_EX,
//   InstrVal_EX                  in   EX/ME register contents
//   DmReq, DmWe, DmAddr, DmWrDat out  registered data-memory request
//   DmAck, DmRdDat               in   memory completion and read data
//   ResultRdDat_ME, WriteReg_ME,
//   RegWrite_ME, InstrVal_ME     out  ME register (writeback / bypass)
//   MemStall_ME                  out  combinational stall request
//   BusErr_ME, MisalignErr_ME    out  one-cycle error pulses
module memory_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    input  logic        InstrVal_EX,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAddr,
    output logic [31:0] DmWrDat,
    input  logic        DmAck,
    input  logic [31:0] DmRdDat,
    output logic [31:0] ResultRdDat_ME,
    output logic [4:0]  WriteReg_ME,
    output logic        RegWrite_ME,
    output logic        InstrVal_ME,
    output logic        MemStall_ME,
    output logic        BusErr_ME,
    output logic        MisalignErr_ME
);

    logic        memOp, aligned;
    meState_t    meState;
    logic        ackStrobe, timeoutStrobe, killNow;
    logic        memToRegLat, regWriteLat;
    logic [4:0]  writeRegLat;

    logic [31:0] resNext;
    logic [4:0]  wregNext;
    logic        rwNext, valNext, misNext, busErrNext;

    assign memOp   = InstrVal_EX & (MemToReg_EX | MemWrite_EX);
    assign aligned = isAligned(Result_EX);

    me_bus_ctl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) uBusCtl (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .memOp        (memOp),
        .aligned      (aligned),
        .Result_EX    (Result_EX),
        .WrDat_EX     (WrDat_EX),
        .WriteReg_EX  (WriteReg_EX),
        .RegWrite_EX  (RegWrite_EX),
        .MemToReg_EX  (MemToReg_EX),
        .MemWrite_EX  (MemWrite_EX),
        .DmAck        (DmAck),
        .DmReq        (DmReq),
        .DmWe         (DmWe),
        .DmAddr       (DmAddr),
        .DmWrDat      (DmWrDat),
        .meState      (meState),
        .ackStrobe    (ackStrobe),
        .timeoutStrobe(timeoutStrobe),
        .killNow      (killNow),
        .memToRegLat  (memToRegLat),
        .regWriteLat  (regWriteLat),
        .writeRegLat  (writeRegLat)
    );

    // Stall covers the IDLE cycle that launches the access plus all of BUSY;
    // flush deliberately does not gate it.
    assign MemStall_ME = ((meState == ME_IDLE) & memOp & aligned) |
                         (meState == ME_BUSY);

    // Next ME register contents; everything defaults to a bubble.
    always_comb begin
        resNext    = '0;
        wregNext   = '0;
        rwNext     = 1'b0;
        valNext    = 1'b0;
        misNext    = 1'b0;
        busErrNext = timeoutStrobe;
        case (meState)
            ME_IDLE: begin
                if (InstrVal_EX && !flush) begin
                    if (!memOp) begin
                        resNext  = Result_EX;
                        wregNext = WriteReg_EX;
                        rwNext   = RegWrite_EX;
                        valNext  = 1'b1;
                    end else if (!aligned) begin
                        misNext  = 1'b1;
                    end
                end
            end
            ME_BUSY: begin
                if (ackStrobe && !killNow) begin
                    resNext  = memToRegLat ? DmRdDat : DmAddr;
                    wregNext = writeRegLat;
                    rwNext   = regWriteLat;
                    valNext  = 1'b1;
                end
            end
            default: ;  // DONE: the EX op is the one just completed, ignore it
        endcase
    end

    dff #(.W(32)) uResReg  (.clk(clk), .reset_n(reset_n), .d(resNext),    .q(ResultRdDat_ME));
    dff #(.W(5))  uWregReg (.clk(clk), .reset_n(reset_n), .d(wregNext),   .q(WriteReg_ME));
    dff #(.W(1))  uRwReg   (.clk(clk), .reset_n(reset_n), .d(rwNext),     .q(RegWrite_ME));
    dff #(.W(1))  uValReg  (.clk(clk), .reset_n(reset_n), .d(valNext),    .q(InstrVal_ME));
    dff #(.W(1))  uMisReg  (.clk(clk), .reset_n(reset_n), .d(misNext),    .q(MisalignErr_ME));
    dff #(.W(1))  uBeReg   (.clk(clk), .reset_n(reset_n), .d(busErrNext), .q(BusErr_ME));

endmodule
